// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle shared by the register block and the stream writer.
// Only the write channels carry traffic in this subsystem; read channels are tied off by masters.
interface axi4_lite_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport m (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/mem_stream_writer.sv
// Streaming write engine: writes each stream word into a circular memory window over AXI4-Lite,
// one single-beat transaction at a time, with a wrapping word pointer and a sticky error flag.
module mem_stream_writer #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned WORDS = 1024,
    localparam int unsigned PW   = $clog2(WORDS)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic [AW-1:0] offset,
    input  logic          enable,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    axi4_lite_if.m        bus,
    output logic [PW-1:0] wr_ptr,
    output logic          wrap,
    output logic          busy,
    output logic          err,
    input  logic          err_clr
);

    localparam int unsigned Shift = $clog2(DW / 8);

    typedef enum logic [1:0] {StIdle, StWrite, StResp} state_e;

    state_e        state_q, state_d;
    logic          arm_q;
    logic [AW-1:0] base_q;
    logic [PW-1:0] wr_ptr_q;
    logic [DW-1:0] wdata_q;
    logic [AW-1:0] awaddr_q;
    logic          awvalid_q;
    logic          wvalid_q;
    logic          wrap_q;
    logic          err_q, err_d;

    logic          idle;
    logic          latch;
    logic          accept;
    logic          aw_ok;
    logic          w_ok;
    logic          b_done;
    logic          b_err;
    logic [AW-1:0] base_eff;
    logic [PW-1:0] ptr_eff;
    logic [AW-1:0] addr_next;

    assign idle   = (state_q == StIdle);
    // arm_q remembers that enable was seen low, so the next IDLE cycle with enable high latches.
    assign latch  = idle & enable & arm_q;
    assign accept = s_valid & s_ready;
    assign aw_ok  = ~awvalid_q | bus.awready;
    assign w_ok   = ~wvalid_q | bus.wready;
    assign b_done = (state_q == StResp) & bus.bvalid;
    assign b_err  = b_done & (bus.bresp != 2'b00);

    // A word accepted on the latch cycle already targets the new base at index 0.
    assign base_eff  = latch ? offset : base_q;
    assign ptr_eff   = latch ? '0 : wr_ptr_q;
    assign addr_next = base_eff + (AW'(ptr_eff) << Shift);

    always_comb begin
        err_d = err_q;
        if (b_err) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StWrite;
            StWrite: if (aw_ok && w_ok) state_d = StResp;
            StResp:  if (bus.bvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_ready    = aresetn & idle & enable;
        bus.bready = (state_q == StResp);
        busy       = ~idle;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            arm_q     <= 1'b1;
            base_q    <= '0;
            wr_ptr_q  <= '0;
            wdata_q   <= '0;
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            arm_q  <= ~enable | (arm_q & ~latch);
            wrap_q <= b_done & (wr_ptr_q == PW'(WORDS - 1));
            err_q  <= err_d;
            if (latch) begin
                base_q <= offset;
            end
            if (latch) begin
                wr_ptr_q <= '0;
            end else if (b_done) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (accept) begin
                wdata_q   <= s_data;
                awaddr_q  <= addr_next;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
            end else begin
                if (bus.awready) awvalid_q <= 1'b0;
                if (bus.wready)  wvalid_q  <= 1'b0;
            end
        end
    end

    assign bus.awaddr  = awaddr_q;
    assign bus.awprot  = 3'b000;
    assign bus.awvalid = awvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = '1;
    assign bus.wvalid  = wvalid_q;
    assign bus.araddr  = '0;
    assign bus.arprot  = 3'b000;
    assign bus.arvalid = 1'b0;
    assign bus.rready  = 1'b0;

    assign wr_ptr = wr_ptr_q;
    assign wrap   = wrap_q;
    assign err    = err_q;

    logic unused_rd;
    assign unused_rd = ^{bus.arready, bus.rdata, bus.rresp, bus.rvalid};

endmodule

// File: tb/tb_mem_stream_writer.sv
// Bench for mem_stream_writer: random AXI slave, transaction-level reference model,
// directed scenarios with literal expectations followed by a randomized run.
module tb_mem_stream_writer;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned WORDS = 8;
    localparam int unsigned BYTES = DW / 8;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] offset;
    logic        enable;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [2:0]  wr_ptr;
    logic        wrap;
    logic        busy;
    logic        err;
    logic        tb_clr;
    logic        slv_clr;
    logic        err_clr;

    int n_checks = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;
    assign err_clr = tb_clr | slv_clr;

    axi4_lite_if #(.AW(AW), .DW(DW)) bus ();

    assign bus.arready = 1'b0;
    assign bus.rdata   = '0;
    assign bus.rresp   = 2'b00;
    assign bus.rvalid  = 1'b0;

    mem_stream_writer #(.AW(AW), .DW(DW), .WORDS(WORDS)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .offset  (offset),
        .enable  (enable),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .bus     (bus),
        .wr_ptr  (wr_ptr),
        .wrap    (wrap),
        .busy    (busy),
        .err     (err),
        .err_clr (err_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the engine must be doing, derived from the word-level rules.
    logic        m_busy = 1'b0;
    logic        m_aw = 1'b0;
    logic        m_w = 1'b0;
    logic        m_arm = 1'b1;
    logic        m_err = 1'b0;
    logic        m_wrap = 1'b0;
    logic [31:0] m_base = '0;
    int          m_ptr = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic        m_set;
    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    int          wrap_cnt = 0;

    always @(negedge aclk) begin
        check("s_ready", 64'(s_ready), 64'(aresetn && !m_busy && enable));
        check("busy", 64'(busy), 64'(m_busy));
        check("awvalid", 64'(bus.awvalid), 64'(m_aw));
        check("wvalid", 64'(bus.wvalid), 64'(m_w));
        check("bready", 64'(bus.bready), 64'(m_busy && !m_aw && !m_w));
        check("wr_ptr", 64'(wr_ptr), 64'(m_ptr));
        check("wrap", 64'(wrap), 64'(m_wrap));
        check("err", 64'(err), 64'(m_err));
        check("arvalid", 64'(bus.arvalid), 64'(0));
        check("rready", 64'(bus.rready), 64'(0));
        if (m_aw) begin
            check("awaddr", 64'(bus.awaddr), 64'(m_addr));
            check("awprot", 64'(bus.awprot), 64'(0));
        end
        if (m_w) begin
            check("wdata", 64'(bus.wdata), 64'(m_data));
            check("wstrb", 64'(bus.wstrb), 64'(4'hF));
        end
        if (wrap === 1'b1) wrap_cnt++;
        if (aresetn && bus.awvalid && bus.awready) aw_log.push_back(bus.awaddr);
        if (aresetn && bus.wvalid && bus.wready) w_log.push_back(bus.wdata);

        if (!aresetn) begin
            m_busy = 1'b0; m_aw = 1'b0; m_w = 1'b0; m_arm = 1'b1;
            m_err = 1'b0; m_wrap = 1'b0; m_base = '0; m_ptr = 0;
        end else begin
            m_wrap = 1'b0;
            m_set  = 1'b0;
            if (!m_busy) begin
                if (enable && m_arm) begin
                    m_base = offset;
                    m_ptr  = 0;
                    m_arm  = 1'b0;
                end
                if (enable && s_valid) begin
                    m_addr = m_base + 32'(m_ptr * BYTES);
                    m_data = s_data;
                    m_busy = 1'b1; m_aw = 1'b1; m_w = 1'b1;
                end
            end else if (m_aw || m_w) begin
                if (m_aw && bus.awready) m_aw = 1'b0;
                if (m_w && bus.wready) m_w = 1'b0;
            end else if (bus.bvalid) begin
                m_set  = (bus.bresp != 2'b00);
                m_wrap = (m_ptr == WORDS - 1);
                m_ptr  = (m_ptr + 1) % WORDS;
                m_busy = 1'b0;
            end
            if (m_set) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (!enable) m_arm = 1'b1;
        end
    end

    // Slave: 0 random readies, 1 awready well before wready, 2 the reverse, 3 stall.
    int   slv_mode = 0;
    logic slv_err_next = 1'b0;
    logic slv_clr_mode = 1'b0;

    initial begin
        logic aw_got, w_got, hs_aw, hs_w, hs_b, av, wv, rst_seen;
        int   bdly, awcnt, wcnt;
        aw_got = 0; w_got = 0; bdly = 0; awcnt = 0; wcnt = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 2'b00; slv_clr = 0;
        forever begin
            @(negedge aclk);
            hs_aw = bus.awvalid & bus.awready;
            hs_w  = bus.wvalid & bus.wready;
            hs_b  = bus.bvalid & bus.bready;
            av = bus.awvalid; wv = bus.wvalid;
            rst_seen = !aresetn;
            @(posedge aclk);
            #1;
            if (rst_seen) begin
                aw_got = 0; w_got = 0; awcnt = 0; wcnt = 0; bdly = 0;
                bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 2'b00; slv_clr = 0;
            end else begin
                if (hs_aw) aw_got = 1;
                if (hs_w) w_got = 1;
                if (hs_b) begin
                    bus.bvalid = 0; bus.bresp = 2'b00; slv_clr = 0; aw_got = 0; w_got = 0;
                end
                awcnt = (av && !hs_aw) ? awcnt + 1 : 0;
                wcnt  = (wv && !hs_w) ? wcnt + 1 : 0;
                case (slv_mode)
                    1: begin bus.awready = 1; bus.wready = (wcnt >= 3); end
                    2: begin bus.wready = 1; bus.awready = (awcnt >= 3); end
                    3: begin bus.awready = 0; bus.wready = 0; end
                    default: begin
                        bus.awready = ($urandom_range(0, 2) != 0);
                        bus.wready  = ($urandom_range(0, 2) != 0);
                    end
                endcase
                if (aw_got && w_got && !bus.bvalid) begin
                    if (bdly == 0) begin
                        bus.bvalid = 1;
                        bus.bresp  = slv_err_next ? 2'b10 : 2'b00;
                        slv_clr    = slv_clr_mode;
                        bdly       = $urandom_range(0, 2);
                    end else begin
                        bdly--;
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d);
        int t;
        @(posedge aclk);
        #1;
        s_valid = 1'b1;
        s_data  = d;
        t = 0;
        @(negedge aclk);
        while (!s_ready && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (!s_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: s_ready still 0 after %0d cycles, required 1", t);
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge aclk);
        while (busy && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", t);
        end
    endtask

    initial begin
        int n0, w0;
        offset = 32'h1000_0000; enable = 1'b1; s_data = '0; s_valid = 1'b0; tb_clr = 1'b0;
        repeat (2) @(negedge aclk);
        check("rst_wr_ptr", 64'(wr_ptr), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_awvalid", 64'(bus.awvalid), 64'(0));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Basic run
        for (int i = 0; i < 4; i++) send_word(32'hA0 + 32'(i));
        wait_idle();
        check("basic_aw0", 64'(aw_log[0]), 64'h1000_0000);
        check("basic_aw1", 64'(aw_log[1]), 64'h1000_0004);
        check("basic_aw2", 64'(aw_log[2]), 64'h1000_0008);
        check("basic_aw3", 64'(aw_log[3]), 64'h1000_000C);
        check("basic_w0", 64'(w_log[0]), 64'hA0);
        check("basic_w3", 64'(w_log[3]), 64'hA3);
        check("basic_ptr", 64'(wr_ptr), 64'(4));
        check("basic_err", 64'(err), 64'(0));

        // Wrap: ptr 4,5,6,7,0
        n0 = wrap_cnt;
        for (int i = 0; i < 5; i++) send_word($urandom);
        wait_idle();
        check("wrap_count", 64'(wrap_cnt - n0), 64'(1));
        check("wrap_aw7", 64'(aw_log[aw_log.size() - 2]), 64'h1000_001C);
        check("wrap_aw0", 64'(aw_log[aw_log.size() - 1]), 64'h1000_0000);
        check("wrap_ptr", 64'(wr_ptr), 64'(1));

        // Split handshakes
        n0 = aw_log.size(); w0 = w_log.size();
        slv_mode = 1;
        send_word(32'h5151_0001);
        wait_idle();
        slv_mode = 2;
        send_word(32'h5151_0002);
        wait_idle();
        slv_mode = 0;
        check("split_aw_count", 64'(aw_log.size() - n0), 64'(2));
        check("split_w_count", 64'(w_log.size() - w0), 64'(2));
        check("split_w_last", 64'(w_log[w_log.size() - 1]), 64'h5151_0002);
        check("split_ptr", 64'(wr_ptr), 64'(3));

        // Error response
        send_word($urandom);
        slv_err_next = 1'b1;
        send_word($urandom);
        wait_idle();
        slv_err_next = 1'b0;
        check("err_set", 64'(err), 64'(1));
        check("err_ptr", 64'(wr_ptr), 64'(5));
        send_word($urandom);
        wait_idle();
        check("err_sticky", 64'(err), 64'(1));
        @(posedge aclk);
        #1;
        tb_clr = 1'b1;
        @(posedge aclk);
        #1;
        tb_clr = 1'b0;
        @(negedge aclk);
        check("err_cleared", 64'(err), 64'(0));
        slv_err_next = 1'b1; slv_clr_mode = 1'b1;
        send_word($urandom);
        wait_idle();
        slv_err_next = 1'b0; slv_clr_mode = 1'b0;
        check("err_set_wins", 64'(err), 64'(1));

        // Offset change while enabled is ignored; ptr 7 then 0
        offset = 32'h2000_0000;
        send_word($urandom);
        send_word($urandom);
        wait_idle();
        check("ofs_ignored_a", 64'(aw_log[aw_log.size() - 2]), 64'h1000_001C);
        check("ofs_ignored_b", 64'(aw_log[aw_log.size() - 1]), 64'h1000_0000);

        // Enable drop during WRITE completes the word
        send_word(32'hDEAD_0001);
        enable = 1'b0;
        wait_idle();
        check("drop_aw", 64'(aw_log[aw_log.size() - 1]), 64'h1000_0004);
        check("drop_s_ready", 64'(s_ready), 64'(0));
        check("drop_ptr", 64'(wr_ptr), 64'(2));

        // Re-enable latches new base and clears ptr
        @(posedge aclk);
        #1;
        enable = 1'b1;
        repeat (2) @(negedge aclk);
        check("reen_ptr", 64'(wr_ptr), 64'(0));
        send_word(32'hBEEF_0000);
        wait_idle();
        check("reen_aw", 64'(aw_log[aw_log.size() - 1]), 64'h2000_0000);
        check("reen_ptr_after", 64'(wr_ptr), 64'(1));

        // Reset mid-transaction
        slv_mode = 3;
        send_word($urandom);
        @(negedge aclk);
        check("mid_awvalid", 64'(bus.awvalid), 64'(1));
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("mid_rst_awvalid", 64'(bus.awvalid), 64'(0));
        check("mid_rst_wvalid", 64'(bus.wvalid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_err", 64'(err), 64'(0));
        check("mid_rst_ptr", 64'(wr_ptr), 64'(0));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        slv_mode = 0;
        send_word(32'h1234_5678);
        wait_idle();
        check("resume_aw", 64'(aw_log[aw_log.size() - 1]), 64'h2000_0000);

        // Randomized run
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(posedge aclk);
                #1;
                enable = 1'b0;
                offset = $urandom;
                repeat ($urandom_range(1, 4)) @(posedge aclk);
                #1;
                enable = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) offset = $urandom;
            slv_err_next = ($urandom_range(0, 5) == 0);
            slv_clr_mode = ($urandom_range(0, 4) == 0);
            tb_clr = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2)) @(posedge aclk);
            send_word($urandom);
            tb_clr = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                enable = 1'b0;
                wait_idle();
                enable = 1'b1;
            end
        end
        wait_idle();
        slv_err_next = 1'b0; slv_clr_mode = 1'b0;
        repeat (3) @(negedge aclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
